// File: rtl/open_drain_receiver_pkg.sv
// Shared types for the open-drain receiver: per-line filter state encoding and
// the level the synchroniser assumes for a released (pulled-up) line.
package open_drain_receiver_pkg;

  typedef enum logic [1:0] {
    REL    = 2'b00,
    QUAL_A = 2'b01,
    QUAL_R = 2'b10,
    ASRT   = 2'b11
  } od_state_e;

  localparam logic LINE_RST_LEVEL = 1'b1;

  // QUAL_R still reports asserted: the line has not yet proven it is released.
  function automatic logic is_asserted_state(input od_state_e s);
    return (s == ASRT) || (s == QUAL_R);
  endfunction

endpackage

// File: rtl/open_drain_receiver_bit_filter.sv
// One line of the receiver: 2-FF synchroniser, tick-qualified glitch filter, pulses.
// state | meaning: REL released, QUAL_A qualifying low, ASRT asserted, QUAL_R qualifying high
module open_drain_receiver_bit_filter
  import open_drain_receiver_pkg::*;
#(
  parameter int FilterTicks = 4,
  parameter int CntWidth    = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic line_i,
  input  logic tick_i,
  output logic asserted_o,
  output logic assert_pulse_o,
  output logic release_pulse_o
);

  localparam logic [CntWidth-1:0] CNT_ONE  = CntWidth'(1);
  localparam logic [CntWidth-1:0] CNT_LAST = CntWidth'(FilterTicks - 1);

  logic                sync1_q, sync2_q;
  od_state_e           state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                asserted_q, asserted_d;
  logic                assert_pulse_q, release_pulse_q;
  logic                low;

  assign low = ~sync2_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q         <= LINE_RST_LEVEL;
      sync2_q         <= LINE_RST_LEVEL;
      state_q         <= REL;
      cnt_q           <= '0;
      asserted_q      <= 1'b0;
      assert_pulse_q  <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      sync1_q         <= line_i;
      sync2_q         <= sync1_q;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      asserted_q      <= asserted_d;
      assert_pulse_q  <= asserted_d & ~asserted_q;
      release_pulse_q <= ~asserted_d & asserted_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      REL: if (tick_i && low) begin
        if (FilterTicks == 1) state_d = ASRT;
        else begin
          state_d = QUAL_A;
          cnt_d   = CNT_ONE;
        end
      end
      QUAL_A: if (tick_i) begin
        if (!low) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = ASRT;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_ONE;
      end
      ASRT: if (tick_i && !low) begin
        if (FilterTicks == 1) state_d = REL;
        else begin
          state_d = QUAL_R;
          cnt_d   = CNT_ONE;
        end
      end
      QUAL_R: if (tick_i) begin
        if (low) begin
          state_d = ASRT;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = REL;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_ONE;
      end
      default: begin
        state_d = REL;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    asserted_d = is_asserted_state(state_q);
  end

  assign asserted_o      = asserted_q;
  assign assert_pulse_o  = assert_pulse_q;
  assign release_pulse_o = release_pulse_q;

endmodule

// File: rtl/open_drain_receiver.sv
// Filtered receiver for Width wired-AND lines; Asserted=1 means a line is held low.
// Define OPEN_DRAIN_RX_LATCH_EN to add sticky Latched bits and the IntReq output.
module open_drain_receiver
  import open_drain_receiver_pkg::*;
#(
  parameter int Width       = 8,
  parameter int FilterTicks = 4,
  parameter int CntWidth    = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [Width:1]   bus_in_i,
  input  logic             sample_tick_i,
  output logic [Width:1]   asserted_o,
  output logic [Width:1]   assert_pulse_o,
  output logic [Width:1]   release_pulse_o
`ifdef OPEN_DRAIN_RX_LATCH_EN
  ,
  input  logic [Width:1]   latch_clr_i,
  output logic [Width:1]   latched_o,
  output logic             int_req_o
`endif
);

  for (genvar i = 1; i <= Width; i++) begin : g_line
    open_drain_receiver_bit_filter #(
      .FilterTicks(FilterTicks),
      .CntWidth   (CntWidth)
    ) u_filter (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .line_i         (bus_in_i[i]),
      .tick_i         (sample_tick_i),
      .asserted_o     (asserted_o[i]),
      .assert_pulse_o (assert_pulse_o[i]),
      .release_pulse_o(release_pulse_o[i])
    );
  end

`ifdef OPEN_DRAIN_RX_LATCH_EN
  logic [Width:1] latched_q, latched_d;
  logic           int_req_q;

  // A new assert event beats a coincident clear so no event is lost.
  assign latched_d = (latched_q & ~latch_clr_i) | assert_pulse_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      latched_q <= '0;
      int_req_q <= 1'b0;
    end else begin
      latched_q <= latched_d;
      int_req_q <= |latched_q;
    end
  end

  assign latched_o = latched_q;
  assign int_req_o = int_req_q;
`endif

endmodule

// File: tb/tb_open_drain_receiver.sv
// Bench for open_drain_receiver: directed scenarios plus random traffic against a
// per-line run-length model of the filter.
module tb_open_drain_receiver;
  localparam int W  = 8;
  localparam int FT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W:1]   bus, clr;
  logic         tick;
  logic [W:1]   asserted, apulse, rpulse;
`ifdef OPEN_DRAIN_RX_LATCH_EN
  logic [W:1]   latched;
  logic         intreq;
`endif

  always #5 clk = ~clk;

  open_drain_receiver #(.Width(W), .FilterTicks(FT), .CntWidth(3)) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .bus_in_i       (bus),
    .sample_tick_i  (tick),
    .asserted_o     (asserted),
    .assert_pulse_o (apulse),
    .release_pulse_o(rpulse)
`ifdef OPEN_DRAIN_RX_LATCH_EN
    ,
    .latch_clr_i    (clr),
    .latched_o      (latched),
    .int_req_o      (intreq)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: bus seen two clocks late; a line flips its accepted level after FT
  // consecutive ticks disagreeing with it; outputs lag the accepted level one clock.
  logic [W:1] m_s1 = '1, m_s2 = '1, m_acc = '0, m_asrt = '0, m_ap = '0, m_rp = '0, m_lat = '0;
  logic       m_irq = 1'b0;
  int         m_run [1:W];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [W:1] low, acc_n;
    if (rst) begin
      m_s1 = '1; m_s2 = '1; m_acc = '0; m_asrt = '0; m_ap = '0; m_rp = '0;
      m_lat = '0; m_irq = 1'b0;
      for (int i = 1; i <= W; i++) m_run[i] = 0;
    end else begin
      low   = ~m_s2;
      acc_n = m_acc;
      if (tick) begin
        for (int i = 1; i <= W; i++) begin
          if (low[i] != m_acc[i]) begin
            m_run[i]++;
            if (m_run[i] == FT) begin
              acc_n[i] = ~m_acc[i];
              m_run[i] = 0;
            end
          end else m_run[i] = 0;
        end
      end
      m_irq  = |m_lat;
      m_lat  = (m_lat & ~clr) | m_ap;
      m_ap   = m_acc & ~m_asrt;
      m_rp   = ~m_acc & m_asrt;
      m_asrt = m_acc;
      m_acc  = acc_n;
      m_s2   = m_s1;
      m_s1   = bus;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("asserted", 32'(asserted), 32'(m_asrt));
    check("assert_pulse", 32'(apulse), 32'(m_ap));
    check("release_pulse", 32'(rpulse), 32'(m_rp));
    check("pulse_overlap", 32'(apulse & rpulse), 32'h0);
`ifdef OPEN_DRAIN_RX_LATCH_EN
    check("latched", 32'(latched), 32'(m_lat));
    check("int_req", 32'(intreq), 32'(m_irq));
`endif
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rise, cnt, seen, mode;
    for (int i = 1; i <= W; i++) m_run[i] = 0;
    rst = 1'b1; bus = '0; tick = 1'b1; clr = '0;

    // reset with all lines low, then time the first assertion of line 1
    settle(2);
    check("reset_asserted", 32'(asserted), 32'h0);
    rst = 1'b0;
    rise = 0; cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (asserted[1] && rise == 0) rise = k;
      if (apulse[1]) cnt++;
    end
    check("rise_clk", 32'(rise), 32'd7);
    check("assert_pulse_count", 32'(cnt), 32'd1);

    // release everything, then a 3-clock glitch on line 3
    bus = '1;
    settle(12);
    bus[3] = 1'b0;
    settle(3);
    bus[3] = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (asserted[3] || apulse[3] || rpulse[3]) seen++;
    end
    check("glitch_line3", 32'(seen), 32'd0);

    // line 5 asserted then released
    bus[5] = 1'b0;
    settle(10);
    check("line5_asserted", 32'(asserted[5]), 32'd1);
    bus[5] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (rpulse[5]) cnt++;
    end
    check("line5_release_pulses", 32'(cnt), 32'd1);
    check("line5_released", 32'(asserted[5]), 32'd0);

    // ticks every 4th clock: line 2 needs four ticks
    bus[2] = 1'b0;
    rise = 0;
    for (int j = 0; j < 20; j++) begin
      tick = (j % 4 == 0);
      step();
      if (asserted[2] && rise == 0) rise = j;
    end
    check("tick4_rise", 32'(rise), 32'd17);
    tick = 1'b1;
    bus = '1;
    settle(12);

    // reset in the middle of qualifying line 1
    bus[1] = 1'b0;
    settle(4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rise = 0; cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (asserted[1] && rise == 0) rise = k;
      if (apulse[1] && rise == 0) cnt++;
    end
    check("midqual_rise_clk", 32'(rise), 32'd7);
    check("midqual_early_pulse", 32'(cnt), 32'd0);
    bus = '1;
    settle(12);

`ifdef OPEN_DRAIN_RX_LATCH_EN
    clr = '1;
    step();
    clr = '0;
    step();
    bus[8] = 1'b0;
    seen = 0;
    for (int k = 0; k < 15 && !seen; k++) begin
      step();
      if (apulse[8]) seen = 1;
    end
    check("latch_pulse_seen", 32'(seen), 32'd1);
    clr[8] = 1'b1;
    step();
    clr = '0;
    check("latch_set_wins", 32'(latched), 32'h80);
    step();
    check("latch_intreq", 32'(intreq), 32'd1);
    clr[8] = 1'b1;
    step();
    clr = '0;
    check("latch_cleared", 32'(latched), 32'h0);
    step();
    check("intreq_cleared", 32'(intreq), 32'd0);
    bus = '1;
    settle(12);
`endif

    // random traffic with varying tick patterns and occasional resets
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0) mode = int'($urandom_range(0, 2));
      for (int i = 1; i <= W; i++) begin
        if ($urandom_range(0, 9) == 0) bus[i] = ~bus[i];
        clr[i] = ($urandom_range(0, 7) == 0);
      end
      case (mode)
        0:       tick = 1'b1;
        1:       tick = (c % 4 == 0);
        default: tick = $urandom_range(0, 1) == 1;
      endcase
      rst = ($urandom_range(0, 249) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
